// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined immediate generator for the decode stage. Forms
//                the sign-extended immediate, the PC-relative target and a
//                B/J target-misalignment flag. A one-entry output register
//                and a one-entry skid buffer sustain full throughput with a
//                registered in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_tgt,
    output logic             out_misalign,
    output logic [TAG_W-1:0] out_tag
);

    // in_instr[0] carries instruction bit 7; subtract this to index by the
    // architectural bit number.
    localparam int       c_OFS    = 7;

    localparam logic [2:0] c_SEL_I    = 3'd0;
    localparam logic [2:0] c_SEL_LD   = 3'd1;
    localparam logic [2:0] c_SEL_S    = 3'd2;
    localparam logic [2:0] c_SEL_B    = 3'd3;
    localparam logic [2:0] c_SEL_J    = 3'd4;
    localparam logic [2:0] c_SEL_LUI  = 3'd5;
    localparam logic [2:0] c_SEL_AUI  = 3'd6;
    localparam logic [2:0] c_SEL_Z    = 3'd7;

    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_tgt;
    logic             w_mis;
    logic             w_sign;

    logic             w_accept;
    logic             w_drain;
    logic             w_out_load_in;
    logic             w_out_load_skid;
    logic             w_skid_load;
    logic             w_out_valid_nxt;
    logic             w_skid_valid_nxt;

    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_out_imm;
    logic [XLEN-1:0]  r_out_tgt;
    logic             r_out_mis;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0]  r_skid_imm;
    logic [XLEN-1:0]  r_skid_tgt;
    logic             r_skid_mis;
    logic [TAG_W-1:0] r_skid_tag;

    assign w_sign = in_instr[31-c_OFS];

    // Assemble the 32-bit immediate for the selected format; every format
    // except Z is sign-extended from instruction bit 31.
    always_comb begin
        w_imm32 = '0;
        case (in_sel)
            c_SEL_I, c_SEL_LD: begin
                w_imm32 = {{20{w_sign}}, in_instr[31-c_OFS:20-c_OFS]};
            end
            c_SEL_S: begin
                w_imm32 = {{20{w_sign}}, in_instr[31-c_OFS:25-c_OFS],
                           in_instr[11-c_OFS:7-c_OFS]};
            end
            c_SEL_B: begin
                w_imm32 = {{20{w_sign}}, in_instr[7-c_OFS],
                           in_instr[30-c_OFS:25-c_OFS],
                           in_instr[11-c_OFS:8-c_OFS], 1'b0};
            end
            c_SEL_J: begin
                w_imm32 = {{12{w_sign}}, in_instr[19-c_OFS:12-c_OFS],
                           in_instr[20-c_OFS], in_instr[30-c_OFS:21-c_OFS],
                           1'b0};
            end
            c_SEL_LUI, c_SEL_AUI: begin
                w_imm32 = {in_instr[31-c_OFS:12-c_OFS], 12'h000};
            end
            c_SEL_Z: begin
                w_imm32 = {27'd0, in_instr[19-c_OFS:15-c_OFS]};
            end
            default: begin
                w_imm32 = '0;
            end
        endcase
    end

    // Z-format keeps bit 31 clear, so a uniform sign extension of the
    // 32-bit value is correct for every format on a wide datapath.
    generate
        if (XLEN > 32) begin : g_ext_wide
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_ext_narrow
            assign w_imm = w_imm32[XLEN-1:0];
        end
    endgenerate

    assign w_tgt = in_pc + w_imm;
    assign w_mis = w_tgt[1] & ((in_sel == c_SEL_B) | (in_sel == c_SEL_J));

    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_drain  = r_out_valid & out_ready;

    // Steering: decide where an accepted beat lands and whether the skid
    // entry moves forward. in_ready is low whenever the skid is full, so an
    // accept never coincides with a full skid.
    always_comb begin
        w_out_load_in    = 1'b0;
        w_out_load_skid  = 1'b0;
        w_skid_load      = 1'b0;
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (r_skid_valid) begin
            if (w_drain) begin
                w_out_load_skid  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_out_valid || out_ready) begin
                w_out_load_in   = 1'b1;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_skid_load      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_drain) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    // Occupancy flags and the registered ready, which mirrors skid vacancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    // Output payload register: loads from the input or from the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_imm <= '0;
            r_out_tgt <= '0;
            r_out_mis <= 1'b0;
            r_out_tag <= '0;
        end else if (w_out_load_in) begin
            r_out_imm <= w_imm;
            r_out_tgt <= w_tgt;
            r_out_mis <= w_mis;
            r_out_tag <= in_tag;
        end else if (w_out_load_skid) begin
            r_out_imm <= r_skid_imm;
            r_out_tgt <= r_skid_tgt;
            r_out_mis <= r_skid_mis;
            r_out_tag <= r_skid_tag;
        end
    end

    // Skid payload register: contents only matter while r_skid_valid is set.
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid_imm <= w_imm;
            r_skid_tgt <= w_tgt;
            r_skid_mis <= w_mis;
            r_skid_tag <= in_tag;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_imm      = r_out_imm;
    assign out_tgt      = r_out_tgt;
    assign out_misalign = r_out_mis;
    assign out_tag      = r_out_tag;

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It takes a decoded instruction word, the immediate-format select and the instruction PC over a valid/ready handshake. It returns the sign-extended XLEN-wide immediate, the PC-relative target (pc + imm) and a target-misalignment flag. A one-entry output register plus one-entry skid buffer give full throughput, single-cycle latency and a registered `in_ready`.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- TAG_W, 5, width of the opaque side-band tag carried with each beat (e.g. rd index).
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  synchronous pipeline flush; discards all held beats.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat; driven from a register.
- in_instr  input  25  instruction bits [31:7].
- in_sel  input  3  format select: 0 I, 1 I-load, 2 S, 3 B, 4 J, 5 U-LUI, 6 U-AUIPC, 7 Z (CSR zimm).
- in_pc  input  XLEN  PC of the instruction.
- in_tag  input  TAG_W  side-band tag.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_imm  output  XLEN  generated immediate.
- out_tgt  output  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_misalign  output  1  target bit 1 set on a B or J beat.
- out_tag  output  TAG_W  tag of the beat.

## Operation
- Immediate formation. Bit indices refer to the full 32-bit instruction. Sign bit is instr[31], extended to XLEN.
  - I and I-load: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[7], instr[30:25], instr[11:8], 0}, bit 12 = instr[31].
  - J: {instr[19:12], instr[20], instr[30:21], 0}, bit 20 = instr[31].
  - U-LUI and U-AUIPC: {instr[31:12], 12'h000}. Sign-extended above bit 31 when XLEN=64.
  - Z: instr[19:15], zero-extended.
- Target is computed for every format. out_misalign = tgt[1] AND (sel==B OR sel==J); it is 0 for all other formats.
- Accept: a beat is taken when in_valid & in_ready.
  - Accepted beat goes to the output register if that register is empty or out_ready=1 in the same cycle.
  - Otherwise it goes to the skid register.
- Drain: on out_valid & out_ready, the skid beat (if any) moves into the output register.
- in_ready register equals NOT skid_valid after each edge. It drops the cycle after the skid fills and rises the cycle after the skid drains.
- Ordering: beats leave in acceptance order. None is duplicated or dropped except by flush or rst.
- Flush: clears both entries. An input beat presented in the flush cycle is not accepted. Next cycle: out_valid=0, in_ready=1.
- rst has priority over flush. rst mid-transfer drops all held beats.

## Timing
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_tgt=0, out_misalign=0, out_tag=0. Skid is empty.
- Latency: a beat accepted at edge N is on the outputs after edge N (valid in cycle N+1).
- Throughput: one beat per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, all out_* stay stable.
- Skid depth is 1. At most 2 beats are held.
- Simultaneous events:
  - Drain and accept in the same cycle with the skid empty: the new beat goes directly to the output register.
  - Drain and accept in the same cycle with the skid full: cannot occur, because in_ready=0.
- Data registers are loaded only on an accept or move. Payload flops need no reset except the output register.

## Test plan
- I-format, XLEN=32: in_instr=0xFFF00093[31:7], sel=0, pc=0x100. Expect out_imm=0xFFFFFFFF, out_tgt=0x000000FF, out_misalign=0, one cycle after accept.
- B-format: instr 0xFE000EE3, sel=3, pc=0x100. Expect out_imm=0xFFFFFFFC, out_tgt=0x000000FC, out_misalign=0.
- J misaligned: instr 0x0020006F, sel=4, pc=0x100. Expect out_imm=0x00000002, out_tgt=0x00000102, out_misalign=1. Same beat with sel=6 gives out_misalign=0.
- XLEN=64 U-LUI: instr 0x800000B7, sel=5. Expect out_imm=0xFFFFFFFF80000000. Z-format with instr[19:15]=0x1F gives out_imm=0x1F.
- Backpressure:
  - Hold out_ready=0 and offer tags 1,2,3 back-to-back. Tag 1 is in the output register, tag 2 in skid, in_ready=0 from the following cycle, tag 3 held.
  - Raise out_ready. Tags appear 1,2,3 on consecutive cycles with stable payload while stalled.
- Flush and reset: with both entries full, assert flush together with in_valid. Next cycle: out_valid=0, in_ready=1, and the flush-cycle beat never appears. Repeat with rst. All outputs return to their reset values.
